// File: rtl/seq_pkg.sv
// Shared types and constants for the datapath sequencer and its index counter.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_FILL,
        S_CALC,
        S_DONE
    } seq_state_t;

    localparam logic MUX_SEL_LFSR = 1'b0;
    localparam logic MUX_SEL_ALU  = 1'b1;
    localparam int   SEQ_MAX_FILL = 16;

endpackage

// File: rtl/seq_index_counter.sv
// Loadable, clearable step counter with a terminal-compare flag against a run-time limit.
module seq_index_counter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_limit,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_at_limit
);

    logic [ADDR_W-1:0] r_idx;

    // Clear outranks load, load outranks increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= i_load_val;
        end else if (i_inc) begin
            r_idx <= r_idx + ADDR_W'(1);
        end
    end

    assign o_idx      = r_idx;
    assign o_at_limit = (r_idx == i_limit);

endmodule

// File: rtl/datapath_sequencer.sv
// Autonomous fill-then-compute controller for the register-bank / LFSR / ALU datapath.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int FILL_COUNT = 8,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        op,
    output logic              busy,
    output logic              done,
    output logic              muxctrl,
    output logic              WEreg,
    output logic              WElfsr,
    output logic [ADDR_W-1:0] addr_rd,
    output logic [ADDR_W-1:0] addr_rs1,
    output logic [ADDR_W-1:0] addr_rs2,
    output logic [1:0]        aluctrl,
    output logic [ADDR_W-1:0] idx
);

    if (FILL_COUNT < 2 || FILL_COUNT > SEQ_MAX_FILL) begin : g_bad_fill
        $fatal(1, "datapath_sequencer: FILL_COUNT out of range 2..16");
    end
    if ((2 * FILL_COUNT - 1) > ((1 << ADDR_W) - 1)) begin : g_bad_addr
        $fatal(1, "datapath_sequencer: ADDR_W too narrow for FILL_COUNT");
    end

    localparam logic [ADDR_W-1:0] FC    = ADDR_W'(FILL_COUNT);
    localparam logic [ADDR_W-1:0] FC_M1 = ADDR_W'(FILL_COUNT - 1);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [1:0]        r_op;
    logic              w_busy_state;
    logic              w_accept;
    logic              w_clr;
    logic              w_load;
    logic              w_inc;
    logic [ADDR_W-1:0] w_limit;
    logic [ADDR_W-1:0] w_idx;
    logic              w_at_limit;

    seq_index_counter #(
        .ADDR_W(ADDR_W)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_load    (w_load),
        .i_load_val(ADDR_W'(1)),
        .i_inc     (w_inc),
        .i_limit   (w_limit),
        .o_idx     (w_idx),
        .o_at_limit(w_at_limit)
    );

    assign w_busy_state = (r_state == S_GEN) || (r_state == S_FILL) || (r_state == S_CALC);
    assign w_accept     = (r_state == S_IDLE) && start;
    // The fill phase ends on FILL_COUNT, the compute phase one pair earlier.
    assign w_limit      = (r_state == S_CALC) ? FC_M1 : FC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op <= op;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_clr    = 1'b0;
        w_load   = 1'b0;
        w_inc    = 1'b0;
        busy     = w_busy_state;
        done     = 1'b0;
        muxctrl  = MUX_SEL_LFSR;
        WEreg    = 1'b0;
        WElfsr   = 1'b0;
        addr_rd  = '0;
        addr_rs1 = '0;
        addr_rs2 = '0;
        aluctrl  = 2'b00;
        idx      = w_idx;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_GEN;
                    w_load = 1'b1;
                end
            end
            S_GEN: begin
                WElfsr = 1'b1;
                w_next = S_FILL;
            end
            S_FILL: begin
                muxctrl = MUX_SEL_LFSR;
                WEreg   = 1'b1;
                addr_rd = w_idx;
                if (w_at_limit) begin
                    w_next = S_CALC;
                    w_load = 1'b1;
                end else begin
                    w_next = S_GEN;
                    w_inc  = 1'b1;
                end
            end
            S_CALC: begin
                muxctrl  = MUX_SEL_ALU;
                WEreg    = 1'b1;
                addr_rs1 = w_idx;
                addr_rs2 = w_idx + ADDR_W'(1);
                addr_rd  = FC + w_idx;
                aluctrl  = r_op;
                if (w_at_limit) begin
                    w_next = S_DONE;
                end else begin
                    w_inc = 1'b1;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
                w_clr  = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
                w_clr  = 1'b1;
            end
        endcase

        // Abort only redirects the next state; this cycle's write is still issued.
        if (abort && w_busy_state) begin
            w_next = S_IDLE;
            w_clr  = 1'b1;
            w_load = 1'b0;
            w_inc  = 1'b0;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: three instances (FILL_COUNT 8, 2, 16) against a cycle-indexed model.
module tb_datapath_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       mux;
        logic       we;
        logic       wel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] alu;
        logic [4:0] idx;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a [3];
    logic       abort_a [3];
    logic [1:0] op_a    [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic       mux_a   [3];
    logic       we_a    [3];
    logic       wel_a   [3];
    logic [4:0] rd_a    [3];
    logic [4:0] rs1_a   [3];
    logic [4:0] rs2_a   [3];
    logic [1:0] alu_a   [3];
    logic [4:0] idx_a   [3];

    logic [7:0] bank   [3][32];
    logic [7:0] lfsr_m [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_sequencer #(.FILL_COUNT(8), .ADDR_W(5)) u0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .abort(abort_a[0]), .op(op_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .muxctrl(mux_a[0]), .WEreg(we_a[0]),
        .WElfsr(wel_a[0]), .addr_rd(rd_a[0]), .addr_rs1(rs1_a[0]), .addr_rs2(rs2_a[0]),
        .aluctrl(alu_a[0]), .idx(idx_a[0])
    );
    datapath_sequencer #(.FILL_COUNT(2), .ADDR_W(5)) u1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .abort(abort_a[1]), .op(op_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .muxctrl(mux_a[1]), .WEreg(we_a[1]),
        .WElfsr(wel_a[1]), .addr_rd(rd_a[1]), .addr_rs1(rs1_a[1]), .addr_rs2(rs2_a[1]),
        .aluctrl(alu_a[1]), .idx(idx_a[1])
    );
    datapath_sequencer #(.FILL_COUNT(16), .ADDR_W(5)) u2 (
        .clk(clk), .rst(rst), .start(start_a[2]), .abort(abort_a[2]), .op(op_a[2]),
        .busy(busy_a[2]), .done(done_a[2]), .muxctrl(mux_a[2]), .WEreg(we_a[2]),
        .WElfsr(wel_a[2]), .addr_rd(rd_a[2]), .addr_rs1(rs1_a[2]), .addr_rs2(rs2_a[2]),
        .aluctrl(alu_a[2]), .idx(idx_a[2])
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [7:0] alu_f(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Datapath stand-in: LFSR and bank driven by the sequencer's control nets.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_m[0] <= 8'h01;
            lfsr_m[1] <= 8'h5a;
            lfsr_m[2] <= 8'hc3;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (wel_a[n]) lfsr_m[n] <= lfsr_next(lfsr_m[n]);
            end
        end
    end

    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (we_a[n]) begin
                bank[n][rd_a[n]] <= mux_a[n] ? alu_f(alu_a[n], bank[n][rs1_a[n]], bank[n][rs2_a[n]])
                                             : lfsr_m[n];
            end
        end
    end

    // Expected controls in cycle c after a start accepted at edge 0.
    function automatic ctrl_t exp_ctrl(input int F, input int c, input logic [1:0] opl);
        ctrl_t e;
        int    k;
        e = '0;
        if (c >= 1 && c <= 2 * F) begin
            e.busy = 1'b1;
            e.idx  = 5'((c + 1) / 2);
            if (c % 2 == 1) begin
                e.wel = 1'b1;
            end else begin
                e.we = 1'b1;
                e.rd = 5'(c / 2);
            end
        end else if (c > 2 * F && c < 3 * F) begin
            k      = c - 2 * F;
            e.busy = 1'b1;
            e.mux  = 1'b1;
            e.we   = 1'b1;
            e.rs1  = 5'(k);
            e.rs2  = 5'(k + 1);
            e.rd   = 5'(F + k);
            e.alu  = opl;
            e.idx  = 5'(k);
        end else if (c == 3 * F) begin
            e.done = 1'b1;
            e.idx  = 5'(F - 1);
        end
        return e;
    endfunction

    function automatic ctrl_t obs(input int n);
        ctrl_t g;
        g.busy = busy_a[n];
        g.done = done_a[n];
        g.mux  = mux_a[n];
        g.we   = we_a[n];
        g.wel  = wel_a[n];
        g.rd   = rd_a[n];
        g.rs1  = rs1_a[n];
        g.rs2  = rs2_a[n];
        g.alu  = alu_a[n];
        g.idx  = idx_a[n];
        return g;
    endfunction

    task automatic test_reset();
        ctrl_t got;
        for (int n = 0; n < 3; n++) begin
            got = obs(n);
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got=%h exp=0", n, got);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_full_run(input int n, input int F, input logic [1:0] opv, input string tag);
        ctrl_t      got;
        ctrl_t      exp;
        logic [7:0] seq [17];
        @(negedge clk);
        seq[0]     = lfsr_m[n];
        start_a[n] = 1'b1;
        op_a[n]    = opv;
        for (int c = 1; c <= 3 * F + 2; c++) begin
            @(negedge clk);
            got = obs(n);
            exp = exp_ctrl(F, c, opv);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", tag, c, got, exp);
            end
            start_a[n] = 1'b0;
            op_a[n]    = 2'($urandom);
        end
        for (int k = 1; k <= F; k++) seq[k] = lfsr_next(seq[k-1]);
        for (int k = 1; k <= F; k++) begin
            checks++;
            if (bank[n][k] !== seq[k]) begin
                errors++;
                $display("FAIL %s fill_reg%0d got=%h exp=%h", tag, k, bank[n][k], seq[k]);
            end
        end
        for (int k = 1; k < F; k++) begin
            checks++;
            if (bank[n][F+k] !== alu_f(opv, seq[k], seq[k+1])) begin
                errors++;
                $display("FAIL %s calc_reg%0d got=%h exp=%h", tag, F + k, bank[n][F+k],
                         alu_f(opv, seq[k], seq[k+1]));
            end
        end
    endtask

    task automatic test_ignore_start();
        ctrl_t      got;
        ctrl_t      exp;
        logic [1:0] opv;
        logic [1:0] opv2;
        opv  = 2'($urandom_range(0, 2));
        opv2 = 2'($urandom);
        @(negedge clk);
        start_a[0] = 1'b1;
        op_a[0]    = opv;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            got = obs(0);
            exp = exp_ctrl(8, c, opv);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ignore_start cycle=%0d got=%h exp=%h", c, got, exp);
            end
            start_a[0] = (c == 5 || c == 24);
            op_a[0]    = (c >= 18) ? 2'b11 : opv;
        end
        start_a[0] = 1'b1;
        op_a[0]    = opv2;
        @(negedge clk);
        got = obs(0);
        exp = exp_ctrl(8, 1, opv2);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL accept_after_idle got=%h exp=%h", got, exp);
        end
        start_a[0] = 1'b0;
        abort_a[0] = 1'b1;
        @(negedge clk);
        abort_a[0] = 1'b0;
        got = obs(0);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL abort_in_gen got=%h exp=0", got);
        end
    endtask

    task automatic test_abort();
        ctrl_t      got;
        ctrl_t      exp;
        logic [1:0] opv;
        logic [7:0] v;
        opv = 2'($urandom);
        @(negedge clk);
        v          = lfsr_m[0];
        start_a[0] = 1'b1;
        op_a[0]    = opv;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            got = obs(0);
            exp = (c <= 10) ? exp_ctrl(8, c, opv) : ctrl_t'('0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort cycle=%0d got=%h exp=%h", c, got, exp);
            end
            start_a[0] = 1'b0;
            abort_a[0] = (c == 10);
        end
        for (int k = 1; k <= 5; k++) v = lfsr_next(v);
        checks++;
        if (bank[0][5] !== v) begin
            errors++;
            $display("FAIL abort_write_kept got=%h exp=%h", bank[0][5], v);
        end
        start_a[0] = 1'b1;
        abort_a[0] = 1'b1;
        op_a[0]    = opv;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            got = obs(0);
            exp = exp_ctrl(8, c, opv);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL start_abort_idle cycle=%0d got=%h exp=%h", c, got, exp);
            end
            start_a[0] = 1'b0;
            abort_a[0] = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        ctrl_t      got;
        ctrl_t      exp;
        logic [1:0] opv;
        opv = 2'($urandom);
        @(negedge clk);
        start_a[0] = 1'b1;
        op_a[0]    = opv;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            got = obs(0);
            exp = exp_ctrl(8, c, opv);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pre_reset cycle=%0d got=%h exp=%h", c, got, exp);
            end
            start_a[0] = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) begin
            got = obs(n);
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL async_reset inst=%0d got=%h exp=0", n, got);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        test_full_run(0, 8, 2'($urandom), "post_reset");
    endtask

    initial begin
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            start_a[n] = 1'b0;
            abort_a[n] = 1'b0;
            op_a[n]    = 2'b00;
        end
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_full_run(0, 8, 2'b00, "nominal");
        test_full_run(1, 2, 2'($urandom), "min_fill");
        test_full_run(2, 16, 2'($urandom), "max_fill");
        test_ignore_start();
        test_abort();
        test_reset_mid();
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            test_full_run(r % 3, (r % 3 == 0) ? 8 : ((r % 3 == 1) ? 2 : 16), 2'($urandom), "random");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Autonomous controller for the register-bank / LFSR / ALU datapath. On a `start` pulse it fills registers 1..FILL_COUNT with successive LFSR values. It then applies one ALU operation to each adjacent register pair, writing the results to registers FILL_COUNT+1..2·FILL_COUNT-1, and reports completion. It drives the same control nets as the manual-mode FSM; the top level selects between the two.

## Interface
- `FILL_COUNT`, default 8: number of LFSR values loaded; legal range 2..16, so every address fits in 1..31.
- `ADDR_W`, default 5: register address width.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request, sampled only in IDLE.
- `abort`  in  1  synchronous cancel, honoured in any busy state.
- `op`  in  2  ALU operation, latched when `start` is accepted.
- `busy`  out  1  high in GEN, FILL, CALC.
- `done`  out  1  one-cycle pulse in DONE.
- `muxctrl`  out  1  0 = LFSR to bank write port, 1 = ALU result.
- `WEreg`  out  1  register-bank write enable.
- `WElfsr`  out  1  one-cycle LFSR advance; new value is valid the next cycle.
- `addr_rd`, `addr_rs1`, `addr_rs2`  out  ADDR_W  bank addresses.
- `aluctrl`  out  2  latched `op`.
- `idx`  out  ADDR_W  current step index, for LED and display debug.

## Operation
- States: IDLE, GEN, FILL, CALC, DONE.
- **IDLE**
  - All outputs 0.
  - `start` = 1: latch `op`, set `idx` = 1, go to GEN.
- **GEN**
  - `WElfsr` = 1, all other controls 0.
  - Next state: FILL.
- **FILL**
  - `muxctrl` = 0, `WEreg` = 1, `addr_rd` = `idx`.
  - If `idx` = FILL_COUNT: set `idx` = 1, go to CALC.
  - Else: increment `idx`, go to GEN.
- **CALC**
  - `muxctrl` = 1, `WEreg` = 1, `addr_rs1` = `idx`, `addr_rs2` = `idx`+1, `addr_rd` = FILL_COUNT+`idx`, `aluctrl` = latched op.
  - If `idx` = FILL_COUNT-1: go to DONE.
  - Else: increment `idx`.
- **DONE**
  - `done` = 1, `busy` = 0.
  - Next state: IDLE unconditionally, with `idx` cleared.
- Control outputs are a Moore decode of state, `idx` and the latched op. Address outputs are 0 whenever they are unused in the current state.
- The bank reads combinationally: the operands addressed in CALC are written into `addr_rd` at the same edge.
- Arithmetic: `idx` and FILL_COUNT+`idx` are ADDR_W wide and never wrap given the legal FILL_COUNT range. FILL_COUNT is checked at elaboration; out-of-range values are a fatal error.

## Timing
- Reset: state IDLE, `idx` = 0, latched op = 0, every output 0. Reset is asynchronous and takes effect immediately, including mid-sequence; partially written registers are not restored.
- With `start` sampled at edge 0:
  - GEN/FILL alternate over cycles 1..2·FILL_COUNT.
  - CALC runs over cycles 2·FILL_COUNT+1..3·FILL_COUNT-1.
  - DONE occurs in cycle 3·FILL_COUNT.
  - Total start-to-done latency is 3·FILL_COUNT cycles.
- `start` while busy or in DONE: ignored, not queued.
- `abort`:
  - Forces IDLE at the next edge with no `done` pulse.
  - The current cycle's write still happens.
  - `abort` in IDLE or DONE has no effect.
- `start` and `abort` in the same cycle in IDLE: `start` wins.
- `op` changes after acceptance: no effect until the next run.

## Structure
- Package `seq_pkg`:
  - state enum `seq_state_t`
  - constants `MUX_SEL_LFSR` = 1'b0 and `MUX_SEL_ALU` = 1'b1
  - `SEQ_MAX_FILL` = 16
- Single sub-module `seq_index_counter`: loadable, clearable ADDR_W up-counter providing `idx` and a terminal-compare flag against a run-time limit.
- The top level instantiates `datapath_sequencer` alongside the manual FSM. A mode bit muxes the control nets and masks `start` while in manual mode.

## Test plan
- Reset: assert `rst` mid-CALC with FILL_COUNT = 8 -> all outputs 0 in the same cycle, state IDLE, and `start` one cycle after release runs a full 24-cycle sequence.
- Nominal run: FILL_COUNT = 8, `op` = 2'b00 -> 8 `WElfsr` pulses at cycles 1,3,…,15, and writes to addresses 1..8 at cycles 2,4,…,16.
  - Cycles 17..23 write addresses 9..15 with (`rs1`,`rs2`) = (1,2)…(7,8).
  - `done` pulses at cycle 24.
  - Scoreboard: reg[8+k] = ALU(op, reg[k], reg[k+1]).
- Minimum FILL_COUNT = 2 -> GEN/FILL at cycles 1..4, a single CALC at cycle 5 writing address 3 from (1,2), `done` at cycle 6.
- `start` pulsed at cycles 5 and 24 (DONE) -> ignored; the next `start` in IDLE is accepted; `op` changed to 2'b11 at cycle 18 -> `aluctrl` stays at the latched value.
- `abort` at cycle 10 -> IDLE at cycle 11, no `done`, `busy` low; simultaneous `start` + `abort` in IDLE -> run starts.
- Maximum FILL_COUNT = 16 -> last write targets address 31 at cycle 47, `done` at cycle 48, no address wrap.
